// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared types and widths for the ALU operation scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int OP_WIDTH       = 4;
    localparam int DATA_IN_WIDTH  = 8;
    localparam int DATA_OUT_WIDTH = 16;

    typedef logic [OP_WIDTH-1:0] alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_t;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_op_scheduler_rr_arbiter_2.sv
// ============================================================================
// Module      : rr_arbiter_2
// Description : Two-way combinational round-robin arbiter, one-hot grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // On a tie the requester that did not win last time gets the grant.
    assign grant[0] = req[0] & (~req[1] |  last_grant);
    assign grant[1] = req[1] & (~req[0] | ~last_grant);

endmodule : rr_arbiter_2

`default_nettype wire

// File: rtl/alu_op_scheduler.sv
// ============================================================================
// Module      : alu_op_scheduler
// Description : Two-requester round-robin sequencer in front of the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_scheduler
    import alu_pkg::*;
#(
    parameter logic [15:0] MULTI_CYCLE_OPS = 16'h00C0,
    parameter int          MC_LATENCY      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [2*OP_WIDTH-1:0]     req_op,
    input  logic [2*DATA_IN_WIDTH-1:0] req_a,
    input  logic [2*DATA_IN_WIDTH-1:0] req_b,
    output logic [DATA_IN_WIDTH-1:0]  alu_a,
    output logic [DATA_IN_WIDTH-1:0]  alu_b,
    output logic [OP_WIDTH-1:0]       alu_sel,
    input  logic [DATA_OUT_WIDTH-1:0] alu_result,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_OUT_WIDTH-1:0] rsp_data,
    output logic                      rsp_id,
    output logic                      busy
);

    localparam logic [3:0] C_MC_LOAD = 4'(MC_LATENCY - 1);

    sched_state_t                state_q,     state_d;
    logic                        last_grant_q, last_grant_d;
    logic [3:0]                  cnt_q,       cnt_d;
    logic [DATA_IN_WIDTH-1:0]    alu_a_q,     alu_a_d;
    logic [DATA_IN_WIDTH-1:0]    alu_b_q,     alu_b_d;
    alu_op_t                     alu_sel_q,   alu_sel_d;
    logic                        rsp_valid_q, rsp_valid_d;
    logic [DATA_OUT_WIDTH-1:0]   rsp_data_q,  rsp_data_d;
    logic                        rsp_id_q,    rsp_id_d;

    logic [1:0]                  w_grant;
    logic                        w_gnt_id;
    alu_op_t                     w_op;
    logic [DATA_IN_WIDTH-1:0]    w_a;
    logic [DATA_IN_WIDTH-1:0]    w_b;

    rr_arbiter_2 u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (w_grant)
    );

    assign w_gnt_id  = w_grant[1];
    assign w_op      = w_gnt_id ? req_op[7:4]  : req_op[3:0];
    assign w_a       = w_gnt_id ? req_a[15:8]  : req_a[7:0];
    assign w_b       = w_gnt_id ? req_b[15:8]  : req_b[7:0];

    // Grants are only visible while idle and out of reset.
    assign req_ready = ((state_q == IDLE) && !rst) ? w_grant : 2'b00;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (|w_grant) begin
                    alu_sel_d    = w_op;
                    alu_a_d      = w_a;
                    alu_b_d      = w_b;
                    rsp_id_d     = w_gnt_id;
                    last_grant_d = w_gnt_id;
                    cnt_d        = MULTI_CYCLE_OPS[w_op] ? C_MC_LOAD : 4'd0;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_data_d  = alu_result;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= 4'd0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);

endmodule : alu_op_scheduler

`default_nettype wire

// File: doc/alu_op_scheduler.md
# alu_op_scheduler

Sequencer and two-way arbiter in front of the ALU datapath. It accepts operation requests from two requesters over valid/ready handshakes and grants them round-robin. It drives the latched operands and the 4-bit operation selector into the ALU and its 16-way, 16-bit result multiplexer. It waits the operation's latency, registers the 16-bit result and returns it, tagged with the requester id, over a valid/ready response channel.

## Interface
Parameters:
- MULTI_CYCLE_OPS, 16'h00C0: bit k set means selector value k is a multi-cycle operation.
- MC_LATENCY, 8: cycles a multi-cycle operation must be held before its result is valid. Legal range 2..15.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  request valid, one bit per requester.
- req_ready  out  2  request accepted, one-hot or zero.
- req_op  in  8  requester k selector on [4k+3:4k].
- req_a  in  16  requester k operand A on [8k+7:8k].
- req_b  in  16  requester k operand B on [8k+7:8k].
- alu_a  out  8  operand A to the ALU.
- alu_b  out  8  operand B to the ALU.
- alu_sel  out  4  selector to the ALU result mux.
- alu_result  in  16  result-mux output.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_data  out  16  registered result.
- rsp_id  out  1  requester that issued the response.
- busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - req_ready is combinational: the grant vector when state == IDLE and rst is low, else zero.
  - Grant goes to the single valid requester. If both are valid, grant goes to the requester that was not granted last.
  - On grant (accept):
    - Latch op into alu_sel, and operands into alu_a and alu_b.
    - Latch the id into rsp_id.
    - Set last_grant to the granted id.
    - Load the 4-bit counter with 0 for single-cycle ops, or MC_LATENCY-1 if MULTI_CYCLE_OPS[op] is set.
    - Go to EXEC.
- **EXEC**
  - alu_a, alu_b and alu_sel are held stable.
  - If the counter is nonzero, decrement it.
  - If the counter is zero, capture alu_result into rsp_data, set rsp_valid, and go to RESP.
- **RESP**
  - rsp_valid, rsp_data and rsp_id are held stable until rsp_valid && rsp_ready.
  - On that handshake, clear rsp_valid and go to IDLE.
  - No request is accepted in RESP or EXEC.
- Requester rule: once req_valid is asserted, it and its op and operand fields stay stable until the matching req_ready. The bench asserts this rule.
- Simultaneous requests with the same last_grant never starve either requester: grants strictly alternate while both stay valid.
- All 16 selector values are legal. The block performs no arithmetic on the data; widths pass through unchanged.

## Timing
- Reset values: state IDLE, rsp_valid 0, rsp_data 16'h0000, rsp_id 0, alu_a/alu_b 0, alu_sel 0, counter 0, busy 0, req_ready 2'b00 while rst is high.
- Reset sets last_grant = 1, so requester 0 wins the first tie.
- Let T be the accept cycle. EXEC occupies T+1..T+L, where L = 1 for single-cycle ops and L = MC_LATENCY for multi-cycle ops. rsp_valid rises at T+1+L.
  - Single-cycle op: response at T+2.
  - MC_LATENCY = 8: response at T+9.
- If the response handshake completes at cycle R, the state is IDLE at R+1, and a new request can be accepted at R+1. Minimum initiation interval is 3 cycles.
- Reset mid-operation (EXEC or RESP): the next cycle shows IDLE with rsp_valid 0. The in-flight operation is dropped and no response is ever emitted for it.

## Structure
- Shared package alu_pkg holds:
  - alu_op_t, a 4-bit selector typedef.
  - sched_state_t, an enum {IDLE, EXEC, RESP}.
  - Constants OP_WIDTH = 4, DATA_IN_WIDTH = 8, DATA_OUT_WIDTH = 16.
- One sub-module, rr_arbiter_2:
  - Inputs: req[1:0] and last_grant.
  - Output: a one-hot grant.
  - Purely combinational; last_grant is registered in the parent.

## Test plan
Bench ALU model: alu_result = {alu_a, alu_b} + alu_sel.

- Single request: after reset, req_valid = 2'b01, op 4'h1, a 8'h12, b 8'h34 at cycle 0 -> req_ready = 2'b01 at cycle 0; rsp_valid at cycle 2 with rsp_data 16'h1235, rsp_id 0; busy 1 in cycles 1-2.
- Arbitration: both requesters valid continuously, op 4'h0 -> grants go 0, 1, 0, 1, each accept 3 cycles apart; rsp_id sequence 0, 1, 0, 1.
- Multi-cycle op: op 4'h6, a 8'hFF, b 8'h01, MC_LATENCY = 8, accepted at T -> alu_sel = 6 stable during T+1..T+8; rsp_valid at T+9 with rsp_data 16'hFF07.
- Backpressure: rsp_ready held low 5 cycles after rsp_valid, requester 1 pending -> rsp_data and rsp_id stable, req_ready stays 2'b00; raising rsp_ready gives IDLE next cycle, with requester 1 granted that cycle.
- Reset mid-operation: rst asserted for 1 cycle at T+4 of an op 4'h7 multi-cycle operation -> rsp_valid 0 and busy 0 at T+5, no response emitted. A subsequent tie is granted to requester 0.
